// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset CPU: control-unit branch codes and fetch FSM states.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_BEQ  = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential, conditional branch or jump target.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic [1:0]      branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] btgt;
  logic [XLEN-1:0] jtgt;

  always_comb begin
    seq  = pc + XLEN'(4);
    btgt = seq + {{14{instr[15]}}, instr[15:0], 2'b00};
    jtgt = {seq[31:28], instr[25:0], 2'b00};
    next_pc = seq;
    case (branch)
      BR_BEQ:  next_pc = zero ? btgt : seq;
      BR_BNE:  next_pc = zero ? seq : btgt;
      BR_JUMP: next_pc = jtgt;
      default: next_pc = seq;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ready fetch from imem, hold for decode until ack.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [1:0]  branch,
  input  logic        zero,
  output logic [31:0] retired
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] next_pc;

  next_pc_logic u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      retired_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Handshake flags are registered from the next state so they stay pure Moore outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          pc_d      = next_pc;
          retired_d = retired_q + XLEN'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == HOLD);
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign instr_valid = instr_valid_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit; three instances with different reset PCs share stimulus.
module tb_fetch_unit;

  localparam int NI = 3;
  localparam logic [31:0] RPC [NI] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h9000_0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic [1:0]  branch;
  logic        zero;

  logic        imem_req    [NI];
  logic [31:0] imem_addr   [NI];
  logic [31:0] instr       [NI];
  logic [5:0]  opcode      [NI];
  logic [5:0]  funct       [NI];
  logic [31:0] pc          [NI];
  logic [31:0] pc_plus4    [NI];
  logic        instr_valid [NI];
  logic [31:0] retired     [NI];

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc  [NI];
  logic [31:0] mret [NI];
  logic [31:0] minstr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    fetch_unit #(.RESET_PC(RPC[g])) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req[g]),
      .imem_addr   (imem_addr[g]),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr[g]),
      .opcode      (opcode[g]),
      .funct       (funct[g]),
      .pc          (pc[g]),
      .pc_plus4    (pc_plus4[g]),
      .instr_valid (instr_valid[g]),
      .instr_ack   (instr_ack),
      .branch      (branch),
      .zero        (zero),
      .retired     (retired[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, using signed arithmetic on the offset.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] iw,
                                           input logic [1:0] br, input logic z);
    logic [31:0] seq;
    int          off;
    logic        taken;
    seq   = cur + 32'd4;
    off   = int'($signed(iw[15:0]));
    taken = (br == 2'b10 && z) || (br == 2'b01 && !z);
    if (br == 2'b11) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    if (taken) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset asynchronously mid-cycle, check reset values, release on the next negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      mpc[g]  = RPC[g];
      mret[g] = '0;
      chk("rst_req", 32'(imem_req[g]), 32'd0);
      chk("rst_valid", 32'(instr_valid[g]), 32'd0);
      chk("rst_pc", pc[g], RPC[g]);
      chk("rst_instr", instr[g], 32'd0);
      chk("rst_retired", retired[g], 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_instr", instr[0], 32'd0);
    imem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int g = 0; g < NI; g++) begin
      chk("f_req", 32'(imem_req[g]), 32'd1);
      chk("f_addr", imem_addr[g], mpc[g]);
    end
    for (int w = 0; w < waits; w++) begin
      imem_rdata = $urandom;
      step();
      chk("wait_req", 32'(imem_req[0]), 32'd1);
      chk("wait_addr", imem_addr[0], mpc[0]);
      chk("wait_valid", 32'(instr_valid[0]), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    minstr = word;
    for (int g = 0; g < NI; g++) begin
      chk("h_valid", 32'(instr_valid[g]), 32'd1);
      chk("h_req", 32'(imem_req[g]), 32'd0);
      chk("h_instr", instr[g], word);
      chk("h_pc", pc[g], mpc[g]);
      chk("h_pc4", pc_plus4[g], mpc[g] + 32'd4);
    end
    chk("h_opcode", 32'(opcode[0]), word >> 26);
    chk("h_funct", 32'(funct[0]), word & 32'h3F);
  endtask

  task automatic ack(input logic [1:0] br, input logic z, input int dly);
    for (int d = 0; d < dly; d++) begin
      branch = 2'($urandom);
      zero   = 1'($urandom);
      step();
      chk("hold_valid", 32'(instr_valid[0]), 32'd1);
      chk("hold_req", 32'(imem_req[0]), 32'd0);
      chk("hold_instr", instr[0], minstr);
      chk("hold_pc", pc[0], mpc[0]);
    end
    branch = br;
    zero = z;
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    branch = 2'($urandom);
    zero = 1'($urandom);
    for (int g = 0; g < NI; g++) begin
      mpc[g]  = ref_next(mpc[g], minstr, br, z);
      mret[g] = mret[g] + 32'd1;
      chk("a_retired", retired[g], mret[g]);
      chk("a_req", 32'(imem_req[g]), 32'd1);
      chk("a_valid", 32'(instr_valid[g]), 32'd0);
      chk("a_addr", imem_addr[g], mpc[g]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    instr_ack = 1'b0;
    branch = 2'b00;
    zero = 1'b0;
    @(negedge clk);
    do_reset();
    step();

    // Zero-wait memory, immediate ack, three sequential addi.
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr[0], 32'(i * 4));
      fetch(32'h2008_0005, 0);
      chk("addi_opcode", 32'(opcode[0]), 32'h08);
      ack(2'b00, 1'($urandom), 0);
      if (i == 0) chk("wrap_addr", imem_addr[1], 32'h0);
    end
    chk("retired3", retired[0], 32'd3);

    // Wait states and late ack.
    fetch($urandom, 3);
    ack(2'b00, 1'b0, 2);

    // Directed branch and jump targets.
    do_reset();
    step();
    fetch(32'h0C00_0010, 0);
    chk("jal_pc4", pc_plus4[2], 32'h9000_0004);
    ack(2'b11, 1'b1, 0);
    chk("jal_tgt", imem_addr[2], 32'h9000_0040);
    chk("j_tgt", imem_addr[0], 32'h0000_0040);
    fetch(32'h1000_FFFE, 0);
    ack(2'b10, 1'b1, 0);
    chk("beq_taken", imem_addr[0], 32'h0000_003C);
    fetch(32'h0800_0010, 0);
    ack(2'b11, 1'b0, 0);
    fetch(32'h1000_FFFE, 0);
    ack(2'b10, 1'b0, 0);
    chk("beq_not", imem_addr[0], 32'h0000_0044);
    fetch(32'h0800_0040, 0);
    ack(2'b11, 1'b0, 0);
    fetch(32'h1400_0003, 0);
    ack(2'b01, 1'b0, 0);
    chk("bne_taken", imem_addr[0], 32'h0000_0110);

    // Retired counter wrap.
    fetch($urandom, 0);
    force gen_dut[0].u_dut.retired_q = 32'hFFFF_FFFF;
    force gen_dut[1].u_dut.retired_q = 32'hFFFF_FFFF;
    force gen_dut[2].u_dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release gen_dut[0].u_dut.retired_q;
    release gen_dut[1].u_dut.retired_q;
    release gen_dut[2].u_dut.retired_q;
    for (int g = 0; g < NI; g++) mret[g] = 32'hFFFF_FFFF;
    ack(2'b00, 1'b0, 0);
    chk("retired_wrap", retired[0], 32'h0);

    // Reset while a memory response is pending in FETCH.
    fetch(32'h2008_0005, 0);
    ack(2'b00, 1'b0, 0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    do_reset();

    // Stray ack in IDLE and FETCH, stray ready in HOLD.
    instr_ack = 1'b1;
    branch = 2'b11;
    step();
    chk("stray_idle_pc", pc[0], RPC[0]);
    step();
    instr_ack = 1'b0;
    chk("stray_fetch_pc", pc[0], RPC[0]);
    chk("stray_fetch_ret", retired[0], 32'd0);
    chk("stray_fetch_req", 32'(imem_req[0]), 32'd1);
    fetch(32'h1234_5678, 0);
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ready = 1'b0;
    chk("stray_hold_instr", instr[0], 32'h1234_5678);
    chk("stray_hold_valid", 32'(instr_valid[0]), 32'd1);
    ack(2'b00, 1'b0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      ack(2'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
